// File: rtl/v74x148_irq_enc_pkg.sv
// Shared types and defaults for the v74x148 interrupt priority encoder.
// The V74X148_IRQ_SYNC_EN macro is consumed by the top, not here.
package v74x148_pkg;

   localparam int N_REQ_DEF  = 8;
   localparam int CODE_W_DEF = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      PRESENT = 2'b01,
      RELEASE = 2'b10
   } state_e;

   // Idle level of an active-low code bus of width w; callers cast down to their width.
   function automatic logic [31:0] allOnes(input int w);
      return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
   endfunction

endpackage

// File: rtl/v74x148_irq_enc_if.sv
// Request/acknowledge/code bundle between interrupt sources, the encoder and its consumer.
// The master modport is the source/consumer side; the slave modport is the encoder.
interface v74x148_irq_enc_if
   import v74x148_pkg::*;
#(
   parameter int N_REQ  = N_REQ_DEF,
   parameter int CODE_W = $clog2(N_REQ)
);

   logic              EI_L;
   logic [N_REQ-1:0]  I_L;
   logic              ACK_L;
   logic [CODE_W-1:0] A_L;
   logic              GS_L;
   logic              EO_L;
   logic [N_REQ-1:0]  PEND;

   modport master (
      output EI_L, I_L, ACK_L,
      input  A_L, GS_L, EO_L, PEND
   );

   modport slave (
      input  EI_L, I_L, ACK_L,
      output A_L, GS_L, EO_L, PEND
   );

endinterface

// File: rtl/v74x148_irq_enc_prienc.sv
// Combinational highest-index-wins priority encoder with an "any request" flag.
module v74x148_prienc #(
   parameter int N_REQ  = 8,
   parameter int CODE_W = 3
) (
   input  logic [N_REQ-1:0]  req_i,
   output logic [CODE_W-1:0] idx_o,
   output logic              any_o
);

   // Ascending scan so the last (highest) set bit overwrites lower ones.
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (req_i[i]) begin
            idx_o = CODE_W'(i);
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/v74x148_irq_enc.sv
// Sequential 74x148-style interrupt encoder: sticky falling-edge capture, 4-phase ACK_L handshake.
// Define V74X148_IRQ_SYNC_EN to pass I_L and ACK_L through 2-flop synchronizers.
module v74x148_irq_enc
   import v74x148_pkg::*;
#(
   parameter int N_REQ  = N_REQ_DEF,
   parameter int CODE_W = CODE_W_DEF
) (
   input logic              CLK,
   input logic              RESET_L,
   v74x148_irq_enc_if.slave bus
);

   logic [N_REQ-1:0]  iEff;
   logic              ackEff;

   state_e            state_q, state_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic [N_REQ-1:0]  pend_q, pend_d;
   logic [N_REQ-1:0]  iPrev_q;
   logic [CODE_W-1:0] aL_q, aL_d;
   logic              gsL_q, gsL_d;
   logic              eoL_q, eoL_d;

   logic [N_REQ-1:0]  fell;
   logic [N_REQ-1:0]  clrMask;
   logic [CODE_W-1:0] encIdx;
   logic              encAny;

`ifdef V74X148_IRQ_SYNC_EN
   logic [N_REQ-1:0] iSync1_q, iSync2_q;
   logic             ackSync1_q, ackSync2_q;

   // Synchronizers reset to the inactive (high) level so reset itself never looks like an edge.
   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         iSync1_q   <= '1;
         iSync2_q   <= '1;
         ackSync1_q <= 1'b1;
         ackSync2_q <= 1'b1;
      end else begin
         iSync1_q   <= bus.I_L;
         iSync2_q   <= iSync1_q;
         ackSync1_q <= bus.ACK_L;
         ackSync2_q <= ackSync1_q;
      end
   end

   assign iEff   = iSync2_q;
   assign ackEff = ackSync2_q;
`else
   assign iEff   = bus.I_L;
   assign ackEff = bus.ACK_L;
`endif

   v74x148_prienc #(
      .N_REQ  (N_REQ),
      .CODE_W (CODE_W)
   ) uEnc (
      .req_i (pend_q),
      .idx_o (encIdx),
      .any_o (encAny)
   );

   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         state_q <= IDLE;
         code_q  <= '0;
         pend_q  <= '0;
         iPrev_q <= '1;
         aL_q    <= CODE_W'(allOnes(CODE_W));
         gsL_q   <= 1'b1;
         eoL_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         pend_q  <= pend_d;
         iPrev_q <= iEff;
         aL_q    <= aL_d;
         gsL_q   <= gsL_d;
         eoL_q   <= eoL_d;
      end
   end

   // A new edge is OR-ed in after the ACK clear so a same-cycle collision keeps the bit pending.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      clrMask = '0;
      fell    = bus.EI_L ? '0 : (iPrev_q & ~iEff);
      if (bus.EI_L) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (encAny) begin
                  code_d  = encIdx;
                  state_d = PRESENT;
               end
            end
            PRESENT: begin
               if (!ackEff) begin
                  clrMask[code_q] = 1'b1;
                  state_d         = RELEASE;
               end
            end
            RELEASE: begin
               if (ackEff) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
      pend_d = (pend_q & ~clrMask) | fell;
   end

   always_comb begin
      gsL_d = 1'b1;
      aL_d  = CODE_W'(allOnes(CODE_W));
      if (state_d == PRESENT) begin
         gsL_d = 1'b0;
         aL_d  = ~code_d;
      end
      eoL_d = ~(!bus.EI_L && (pend_d == '0) && (state_d == IDLE));
   end

   assign bus.A_L  = aL_q;
   assign bus.GS_L = gsL_q;
   assign bus.EO_L = eoL_q;
   assign bus.PEND = pend_q;

endmodule

// File: tb/tb_v74x148_irq_enc.sv
// Directed self-checking bench for v74x148_irq_enc; build with V74X148_IRQ_SYNC_EN to test the synchronized variant.
module tb_v74x148_irq_enc;

`ifdef V74X148_IRQ_SYNC_EN
   localparam int L = 2;
`else
   localparam int L = 0;
`endif

   logic CLK = 1'b0;
   logic RESET_L;
   int   checkCount = 0;
   int   failCount  = 0;

   v74x148_irq_enc_if bus ();

   v74x148_irq_enc dut (
      .CLK     (CLK),
      .RESET_L (RESET_L),
      .bus     (bus)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic ei, input logic [7:0] req, input logic ack);
      bus.EI_L  = ei;
      bus.I_L   = req;
      bus.ACK_L = ack;
   endtask

   // Inputs change and outputs are sampled 1ns after a rising edge.
   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic checkAll(input string tag, input logic [2:0] a, input logic gs,
                           input logic eo, input logic [7:0] pend);
      checkOutput({tag, ".A_L"},  32'(bus.A_L),  32'(a));
      checkOutput({tag, ".GS_L"}, 32'(bus.GS_L), 32'(gs));
      checkOutput({tag, ".EO_L"}, 32'(bus.EO_L), 32'(eo));
      checkOutput({tag, ".PEND"}, 32'(bus.PEND), 32'(pend));
   endtask

   initial begin
      RESET_L = 1'b0;
      applyStimulus(1'b0, 8'hFF, 1'b1);
      tick(3);
      checkAll("rst", 3'b111, 1'b1, 1'b1, 8'h00);
      RESET_L = 1'b1;
      tick(1);
      checkAll("idle", 3'b111, 1'b1, 1'b0, 8'h00);

      // Single request on line 2.
      applyStimulus(1'b0, 8'hFB, 1'b1);
      tick(1 + L);
      checkOutput("single.pend", 32'(bus.PEND), 32'h04);
      checkOutput("single.gsEarly", 32'(bus.GS_L), 32'h1);
      tick(1);
      checkAll("single.pres", 3'b101, 1'b0, 1'b1, 8'h04);
      applyStimulus(1'b0, 8'hFF, 1'b0);
      tick(1 + L);
      checkAll("single.ack", 3'b111, 1'b1, 1'b1, 8'h00);
      applyStimulus(1'b0, 8'hFF, 1'b1);
      tick(1 + L);
      checkAll("single.done", 3'b111, 1'b1, 1'b0, 8'h00);

      // Line 1 presented, then higher-priority line 6 arrives and must wait.
      applyStimulus(1'b0, 8'hFD, 1'b1);
      tick(1 + L);
      checkOutput("prio.pend1", 32'(bus.PEND), 32'h02);
      tick(1);
      checkOutput("prio.code1", 32'(bus.A_L), 32'h6);
      tick(1);
      applyStimulus(1'b0, 8'hBD, 1'b1);
      tick(1 + L);
      checkAll("prio.hold", 3'b110, 1'b0, 1'b1, 8'h42);
      applyStimulus(1'b0, 8'hBD, 1'b0);
      tick(1 + L);
      checkAll("prio.ack1", 3'b111, 1'b1, 1'b1, 8'h40);
      applyStimulus(1'b0, 8'hBD, 1'b1);
      tick(1 + L);
      checkOutput("prio.idle.gs", 32'(bus.GS_L), 32'h1);
      tick(1);
      checkAll("prio.code6", 3'b001, 1'b0, 1'b1, 8'h40);
      applyStimulus(1'b0, 8'hBD, 1'b0);
      tick(1 + L);
      checkOutput("prio.clr6", 32'(bus.PEND), 32'h00);
      applyStimulus(1'b0, 8'hFF, 1'b1);
      tick(3 + L);

      // Disable aborts the presentation of line 4 and blocks capture of line 0.
      applyStimulus(1'b0, 8'hEF, 1'b1);
      tick(2 + L);
      checkOutput("dis.code4", 32'(bus.A_L), 32'h3);
      applyStimulus(1'b1, 8'hEF, 1'b1);
      tick(1);
      checkAll("dis.off", 3'b111, 1'b1, 1'b1, 8'h10);
      applyStimulus(1'b1, 8'hEE, 1'b1);
      tick(2 + L);
      checkAll("dis.block", 3'b111, 1'b1, 1'b1, 8'h10);
      applyStimulus(1'b0, 8'hEE, 1'b1);
      tick(2);
      checkAll("dis.again", 3'b011, 1'b0, 1'b1, 8'h10);
      applyStimulus(1'b0, 8'hEE, 1'b0);
      tick(1 + L);
      checkOutput("dis.clr", 32'(bus.PEND), 32'h00);
      applyStimulus(1'b0, 8'hFF, 1'b1);
      tick(3 + L);

      // ACK_L sampled low on the same edge a new falling edge hits presented line 3.
      applyStimulus(1'b0, 8'hF7, 1'b1);
      tick(2 + L);
      checkOutput("coll.code3", 32'(bus.A_L), 32'h4);
      applyStimulus(1'b0, 8'hFF, 1'b1);
      tick(1 + L);
      applyStimulus(1'b0, 8'hF7, 1'b0);
      tick(1 + L);
      checkAll("coll.ack", 3'b111, 1'b1, 1'b1, 8'h08);
      applyStimulus(1'b0, 8'hF7, 1'b1);
      tick(1 + L);
      tick(1);
      checkAll("coll.again", 3'b100, 1'b0, 1'b1, 8'h08);
      applyStimulus(1'b0, 8'hF7, 1'b0);
      tick(1 + L);
      applyStimulus(1'b0, 8'hFF, 1'b1);
      tick(3 + L);
      checkOutput("coll.empty", 32'(bus.PEND), 32'h00);

      // Asynchronous reset while presenting index 7 with lines 7 and 5 pending.
      applyStimulus(1'b0, 8'h5F, 1'b1);
      tick(2 + L);
      checkAll("mid.pres", 3'b000, 1'b0, 1'b1, 8'hA0);
      RESET_L = 1'b0;
      #1;
      checkAll("mid.rst", 3'b111, 1'b1, 1'b1, 8'h00);
      tick(1);
      RESET_L = 1'b1;
      tick(1 + L);
      checkOutput("mid.recap", 32'(bus.PEND), 32'hA0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
